// File: rtl/dmem_port.sv
// Data-memory port: turns a MEM-stage load/store into one cache request and holds the pipeline until it completes.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the cache and raise a one-cycle misaligned flag.
`timescale 1ns/1ps

module dmem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] mdrreg_out,
  output logic [3:0]  rmask,
  output logic        done,
  output logic        stall
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        load_q, load_d;
  logic [29:0] waddr_q, waddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdr_q, mdr_d;
  logic [3:0]  rmask_q, rmask_d;

  logic        mem_req;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign mem_req = mem_valid & (is_load | is_store);

  // The half mask only looks at addr[1] and the word mask at nothing, so offending
  // low bits are already treated as zero when the trap is not built in.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data;
    case (funct3)
      3'b000, 3'b100: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{store_data[7:0]}};
      end
      3'b001, 3'b101: begin
        be_calc    = 4'b0011 << {addr[1], 1'b0};
        wdata_calc = {2{store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_calc;
  logic mis_q, mis_d;

  always_comb begin
    mis_calc = 1'b0;
    case (funct3)
      3'b000, 3'b100: mis_calc = 1'b0;
      3'b001, 3'b101: mis_calc = addr[0];
      default:        mis_calc = |addr[1:0];
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    rmask_d = rmask_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          load_d  = is_load;
          waddr_d = addr[31:2];
          be_d    = be_calc;
          wdata_d = wdata_calc;
`ifdef MISALIGN_TRAP_EN
          if (mis_calc) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        // Request fields stay frozen until the cache answers; the pipeline inputs are ignored.
        if (dmem_resp) begin
          state_d = DONE;
          if (load_q) begin
            mdr_d   = dmem_rdata;
            rmask_d = be_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      rmask_q <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      rmask_q <= rmask_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign misaligned = mis_q;
`endif

  assign dmem_read        = (state_q == BUSY) &  load_q;
  assign dmem_write       = (state_q == BUSY) & ~load_q;
  assign dmem_address     = {waddr_q, 2'b00};
  assign dmem_byte_enable = be_q;
  assign dmem_wdata       = wdata_q;
  assign mdrreg_out       = mdr_q;
  assign rmask            = rmask_q;
  assign done             = (state_q == DONE);
  assign stall            = mem_req & (state_q != DONE);

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: table of load/store vectors through a request/completion
// scoreboard, plus hand-written reset, idle-response, non-memory and back-to-back sequences.
`timescale 1ns/1ps

module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mdrreg_out;
  logic [3:0]  rmask;
  logic        done, stall;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  dmem_port dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .is_load          (is_load),
    .is_store         (is_store),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .mdrreg_out       (mdrreg_out),
    .rmask            (rmask),
    .done             (done),
    .stall            (stall)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned       (misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
  } req_exp_t;

  typedef struct {
    logic        trap;
    logic [3:0]  rmask;
    logic [31:0] mdr;
  } cpl_exp_t;

  req_exp_t    req_q[$];
  cpl_exp_t    cpl_q[$];
  logic [3:0]  m_rmask;
  logic [31:0] m_mdr;
  vec_t        vecs[10];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic traps(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a[1:0] != 2'b00;
    endcase
`else
    return (f3 == 3'b111) && (a === 32'hx);
`endif
  endfunction

  task automatic check_req(input req_exp_t r, input string tag);
    check({tag, ".read"},  dmem_read,        r.rd);
    check({tag, ".write"}, dmem_write,       r.wr);
    check({tag, ".addr"},  dmem_address,     r.a);
    check({tag, ".be"},    dmem_byte_enable, r.be);
    if (r.chk_wd) check({tag, ".wdata"}, dmem_wdata, r.wd);
  endtask

  // Drives one access just after a rising edge and pushes what the DUT must produce.
  task automatic drive(input vec_t v);
    mem_valid  = 1'b1;
    is_load    = v.ld;
    is_store   = ~v.ld;
    funct3     = v.f3;
    addr       = v.a;
    store_data = v.sd;
    if (traps(v.f3, v.a)) begin
      cpl_q.push_back('{1'b1, m_rmask, m_mdr});
    end else begin
      req_q.push_back('{v.ld, ~v.ld, v.e_addr, v.e_be, v.e_wdata, ~v.ld});
      if (v.ld) begin
        m_rmask = v.e_be;
        m_mdr   = v.rd;
      end
      cpl_q.push_back('{1'b0, m_rmask, m_mdr});
    end
  endtask

  // Runs one access from an IDLE state up to the negedge of its DONE cycle.
  task automatic run_access(input vec_t v, input string tag);
    req_exp_t r;
    cpl_exp_t c;
    int waited;
    logic tr;
    tr = traps(v.f3, v.a);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
    check({tag, ".stall_idle"}, stall, 1'b1);
    check({tag, ".no_early_req"}, dmem_read | dmem_write, 1'b0);
    if (!tr) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(dmem_read | dmem_write) && waited < 8);
      if (!(dmem_read | dmem_write)) begin
        check({tag, ".req_timeout"}, 32'd0, 32'd1);
        req_q.delete();
        cpl_q.delete();
        mem_valid = 1'b0;
        return;
      end
      check({tag, ".req_latency"}, waited, 1);
      if (req_q.size() == 0) begin
        check({tag, ".sb_req_empty"}, 32'd0, 32'd1);
        return;
      end
      r = req_q.pop_front();
      check_req(r, tag);
      check({tag, ".stall_busy"}, stall, 1'b1);
      for (int i = 0; i < v.dly; i++) begin
        addr       = $urandom;
        funct3     = 3'($urandom);
        store_data = $urandom;
        is_load    = ~is_load;
        is_store   = ~is_load;
        dmem_rdata = $urandom;
        @(negedge clk);
        check_req(r, {tag, ".hold"});
        check({tag, ".stall_hold"}, stall, 1'b1);
        check({tag, ".done_early"}, done, 1'b0);
      end
      dmem_resp  = 1'b1;
      dmem_rdata = v.rd;
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
    end else begin
      @(negedge clk);
    end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".strobes_off"}, dmem_read | dmem_write, 1'b0);
    check({tag, ".stall_done"}, stall, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check({tag, ".misaligned"}, misaligned, tr);
`endif
    if (cpl_q.size() == 0) begin
      check({tag, ".sb_cpl_empty"}, 32'd0, 32'd1);
      return;
    end
    c = cpl_q.pop_front();
    check({tag, ".rmask"}, rmask, c.rmask);
    check({tag, ".mdr"}, mdrreg_out, c.mdr);
  endtask

  task automatic finish_idle(input string tag);
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done_once"}, done, 1'b0);
    check({tag, ".idle_strobes"}, dmem_read | dmem_write, 1'b0);
    check({tag, ".rmask_hold"}, rmask, m_rmask);
    check({tag, ".mdr_hold"}, mdrreg_out, m_mdr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 3'b010, 32'h0000_1006, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 3, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'hBAD0_BAD0, 1, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5};
    vecs[2] = '{1'b1, 3'b001, 32'h0000_3002, 32'h0000_0000, 32'h8001_7FFF, 2, 32'h0000_3000, 4'b1100, 32'h0};
    vecs[3] = '{1'b1, 3'b000, 32'h0000_0011, 32'h0000_0000, 32'h1234_5678, 0, 32'h0000_0010, 4'b0010, 32'h0};
    vecs[4] = '{1'b0, 3'b001, 32'h0000_0022, 32'hCAFE_BEEF, 32'hBAD0_BAD0, 1, 32'h0000_0020, 4'b1100, 32'hBEEF_BEEF};
    vecs[5] = '{1'b1, 3'b100, 32'h0000_0013, 32'h0000_0000, 32'hAABB_CCDD, 0, 32'h0000_0010, 4'b1000, 32'h0};
    vecs[6] = '{1'b1, 3'b101, 32'h0000_0040, 32'h0000_0000, 32'h0BAD_F00D, 4, 32'h0000_0040, 4'b0011, 32'h0};
    vecs[7] = '{1'b1, 3'b010, 32'h0000_4001, 32'h0000_0000, 32'h55AA_55AA, 1, 32'h0000_4000, 4'b1111, 32'h0};
    vecs[8] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0000_1234, 32'hBAD0_BAD0, 0, 32'h0000_0000, 4'b1100, 32'h1234_1234};
    vecs[9] = '{1'b0, 3'b000, 32'h0000_0000, 32'h0000_01FF, 32'hBAD0_BAD0, 2, 32'h0000_0000, 4'b0001, 32'hFFFF_FFFF};

    rst = 1'b0; mem_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    m_rmask = '0; m_mdr = '0;
    #1 rst = 1'b1;
    #3;
    check("rst.strobes", {dmem_read, dmem_write}, 2'b00);
    check("rst.done", done, 1'b0);
    check("rst.stall", stall, 1'b0);
    check("rst.mdr", mdrreg_out, 32'h0);
    check("rst.rmask", rmask, 4'h0);
`ifdef MISALIGN_TRAP_EN
    check("rst.misaligned", misaligned, 1'b0);
`endif
    #8 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
      finish_idle($sformatf("vec%0d", i));
    end

    // Back-to-back LB then SW: the store's request follows the IDLE cycle after done.
    v = '{1'b1, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_00C3, 1, 32'h0000_0010, 4'b0001, 32'h0};
    run_access(v, "b2b_lb");
    v = '{1'b0, 3'b010, 32'h0000_0014, 32'h0F0F_1234, 32'hBAD0_BAD0, 0, 32'h0000_0014, 4'b1111, 32'h0F0F_1234};
    run_access(v, "b2b_sw");
    finish_idle("b2b_sw");
    check("b2b.rmask_kept", rmask, 4'b0001);

    // Cache response while IDLE must be ignored.
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    dmem_resp  = 1'b0;
    check("idle_resp.done", done, 1'b0);
    check("idle_resp.mdr", mdrreg_out, m_mdr);
    @(negedge clk);
    check("idle_resp.done2", done, 1'b0);

    // Non-memory instruction never leaves IDLE.
    mem_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
    #1 check("nonmem.stall", stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem.strobes", dmem_read | dmem_write, 1'b0);
      check("nonmem.done", done, 1'b0);
    end
    mem_valid = 1'b0;

    // Reset in the middle of a load: strobes drop at once, late response does nothing.
    @(posedge clk);
    #1;
    mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy.read_before", dmem_read, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_busy.read", dmem_read, 1'b0);
    check("rst_busy.write", dmem_write, 1'b0);
    check("rst_busy.mdr", mdrreg_out, 32'h0);
    check("rst_busy.rmask", rmask, 4'h0);
    #1 rst = 1'b0;
    mem_valid = 1'b0;
    m_rmask = '0;
    m_mdr   = '0;
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_resp  = 1'b0;
    check("rst_busy.no_done", done, 1'b0);
    check("rst_busy.mdr_after", mdrreg_out, 32'h0);
    @(negedge clk);
    check("rst_busy.no_done2", done, 1'b0);
    check("rst_busy.strobes", dmem_read | dmem_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
